mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 35 +++
 rtl/mem_access_unit.sv | 133 +++++++++++++
 tb/tb_mem_access_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Memory-stage bus for mem_access_unit: pipeline control/operands, data-memory
// request/response, and the results returned to the pipeline.
interface mem_access_unit_if;
    logic        valid_in;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [3:0]  dmem_mbe;
    logic [31:0] dmem_wdata;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        trap;

    modport master (
        input  valid_in, mem_read, mem_write, funct3, addr, store_data,
        input  dmem_resp, dmem_rdata,
        output dmem_read, dmem_write, dmem_address, dmem_mbe, dmem_wdata,
        output stall, done, load_data, trap
    );

    modport slave (
        output valid_in, mem_read, mem_write, funct3, addr, store_data,
        output dmem_resp, dmem_rdata,
        input  dmem_read, dmem_write, dmem_address, dmem_mbe, dmem_wdata,
        input  stall, done, load_data, trap
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit for the memory stage: validates alignment and funct3, issues
// one registered data-memory request, and formats the returned load word.
module mem_access_unit (
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.master bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic        r_read;
    logic        r_write;
    logic [31:0] r_address;
    logic [3:0]  r_mbe;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [1:0]  r_offset;
    logic [31:0] r_load_data;
    logic        r_done;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_any_req;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_idle_req;
    logic        w_trap;
    logic        w_accept;
    logic [1:0]  w_size;
    logic [3:0]  w_mbe;
    logic [31:0] w_wdata;
    logic [31:0] w_lane;
    logic [31:0] w_load_fmt;

    assign w_is_load  = bus.mem_read & ~bus.mem_write;
    assign w_is_store = bus.mem_write & ~bus.mem_read;
    assign w_any_req  = bus.valid_in & (bus.mem_read | bus.mem_write);
    assign w_size     = bus.funct3[1:0];

    // Loads allow funct3 0,1,2,4,5; stores allow 0,1,2; both strobes is never legal.
    assign w_illegal = (bus.mem_read & bus.mem_write)
                     | (w_is_load  & ((bus.funct3 == 3'd3) || (bus.funct3[2:1] == 2'b11)))
                     | (w_is_store & (bus.funct3 > 3'd2));

    assign w_misaligned = ((w_size == 2'd2) && (bus.addr[1:0] != 2'b00))
                        || ((w_size == 2'd1) && bus.addr[0]);

    // Only IDLE looks at the inputs; in BUSY/DONE they still describe the held instruction.
    assign w_idle_req = (r_state == S_IDLE) & ~rst & w_any_req;
    assign w_trap     = w_idle_req & (w_illegal | w_misaligned);
    assign w_accept   = w_idle_req & ~w_illegal & ~w_misaligned;

    always_comb begin
        w_mbe = 4'b1111;
        case (w_size)
            2'd0:    w_mbe = 4'b0001 << bus.addr[1:0];
            2'd1:    w_mbe = 4'b0011 << bus.addr[1:0];
            default: w_mbe = 4'b1111;
        endcase
    end

    assign w_wdata = bus.store_data << {bus.addr[1:0], 3'b000};
    assign w_lane  = bus.dmem_rdata >> {r_offset, 3'b000};

    always_comb begin
        w_load_fmt = w_lane;
        case (r_funct3)
            3'd0:    w_load_fmt = {{24{w_lane[7]}}, w_lane[7:0]};
            3'd1:    w_load_fmt = {{16{w_lane[15]}}, w_lane[15:0]};
            3'd4:    w_load_fmt = {24'd0, w_lane[7:0]};
            3'd5:    w_load_fmt = {16'd0, w_lane[15:0]};
            default: w_load_fmt = w_lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_address   <= 32'd0;
            r_mbe       <= 4'd0;
            r_wdata     <= 32'd0;
            r_funct3    <= 3'd0;
            r_offset    <= 2'd0;
            r_load_data <= 32'd0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_read    <= w_is_load;
                        r_write   <= w_is_store;
                        r_address <= {bus.addr[31:2], 2'b00};
                        r_mbe     <= w_mbe;
                        r_wdata   <= w_wdata;
                        r_funct3  <= bus.funct3;
                        r_offset  <= bus.addr[1:0];
                        r_state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (bus.dmem_resp) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        if (r_read) begin
                            r_load_data <= w_load_fmt;
                        end
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.dmem_read    = r_read;
    assign bus.dmem_write   = r_write;
    assign bus.dmem_address = r_address;
    assign bus.dmem_mbe     = r_mbe;
    assign bus.dmem_wdata   = r_wdata;
    assign bus.load_data    = r_load_data;
    assign bus.done         = r_done;
    assign bus.trap         = w_trap;
    assign bus.stall        = ~rst & ((r_state == S_BUSY) | w_accept);
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboarded bench for mem_access_unit: directed loads/stores, traps, reset abort.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_access_unit_if bus_if ();

    mem_access_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  mbe;
        logic [31:0] wdata;
        logic        wr;
        int          hold;
    } req_t;

    typedef struct {
        logic        ld;
        logic [31:0] data;
    } done_t;

    req_t  req_q[$];
    done_t done_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Monitor: requests are checked when a strobe rises, held-length when it falls.
    req_t cur;
    bit   in_req = 1'b0;
    int   held   = 0;
    always @(negedge clk) begin
        if (bus_if.dmem_read || bus_if.dmem_write) begin
            if (!in_req) begin
                in_req = 1'b1;
                held   = 1;
                check("req_expected", 32'(req_q.size() != 0), 32'd1);
                if (req_q.size() != 0) begin
                    cur = req_q.pop_front();
                    check("req_addr",  bus_if.dmem_address, cur.addr);
                    check("req_mbe",   {28'd0, bus_if.dmem_mbe}, {28'd0, cur.mbe});
                    check("req_wdata", bus_if.dmem_wdata, cur.wdata);
                    check("req_kind",  {30'd0, bus_if.dmem_write, bus_if.dmem_read},
                                       {30'd0, cur.wr, ~cur.wr});
                end
            end else begin
                held++;
                check("req_stable", 32'({bus_if.dmem_address, bus_if.dmem_mbe, bus_if.dmem_wdata}
                                        == {cur.addr, cur.mbe, cur.wdata}), 32'd1);
            end
        end else if (in_req) begin
            in_req = 1'b0;
            check("strobe_hold", held, cur.hold);
        end
        if (bus_if.done) begin
            done_t d;
            check("done_expected", 32'(done_q.size() != 0), 32'd1);
            if (done_q.size() != 0) begin
                d = done_q.pop_front();
                if (d.ld) check("load_data", bus_if.load_data, d.data);
            end
        end
    end

    task automatic drive(input logic vi, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
        bus_if.valid_in   = vi;
        bus_if.mem_read   = rd;
        bus_if.mem_write  = wr;
        bus_if.funct3     = f3;
        bus_if.addr       = a;
        bus_if.store_data = sd;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    // Issues one access; dmem_resp is returned dly cycles after the first BUSY cycle.
    task automatic do_access(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] sd, input logic [31:0] rd, input int dly,
                             input logic [31:0] e_addr, input logic [3:0] e_mbe,
                             input logic [31:0] e_wdata, input logic [31:0] e_load);
        req_t  r;
        done_t d;
        int    waited = 0;
        bit    got_done = 1'b0;
        r.addr = e_addr; r.mbe = e_mbe; r.wdata = e_wdata; r.wr = ~ld; r.hold = dly + 1;
        d.ld = ld; d.data = e_load;
        req_q.push_back(r);
        done_q.push_back(d);
        @(negedge clk);
        drive(1'b1, ld, ~ld, f3, a, sd);
        #1;
        check("accept_stall", {31'd0, bus_if.stall}, 32'd1);
        for (int c = 2; c <= dly + 6 && !got_done; c++) begin
            @(negedge clk);
            bus_if.dmem_resp = 1'b0;
            if (bus_if.done) begin
                got_done = 1'b1;
                check("latency", c, dly + 3);
                check("done_stall", {31'd0, bus_if.stall}, 32'd0);
            end else begin
                check("busy_stall", {31'd0, bus_if.stall}, 32'd1);
                if (waited == dly) begin
                    bus_if.dmem_resp  = 1'b1;
                    bus_if.dmem_rdata = rd;
                end
                waited++;
            end
        end
        if (!got_done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic trap_case(input string name, input logic vi, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] a, input logic exp_trap);
        @(negedge clk);
        drive(vi, rd, wr, f3, a, 32'h1234_5678);
        #1;
        check({name, "_trap"},  {31'd0, bus_if.trap},  {31'd0, exp_trap});
        check({name, "_stall"}, {31'd0, bus_if.stall}, 32'd0);
        @(negedge clk);
        check({name, "_quiet"}, {30'd0, bus_if.dmem_read | bus_if.dmem_write, bus_if.done}, 32'd0);
    endtask

    initial begin
        req_t r;
        drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_0100, 32'd0);
        bus_if.dmem_resp  = 1'b0;
        bus_if.dmem_rdata = 32'd0;

        // Reset with a legal access presented: no stall, no trap, outputs cleared.
        repeat (3) @(negedge clk);
        check("rst_stall", {31'd0, bus_if.stall}, 32'd0);
        check("rst_trap",  {31'd0, bus_if.trap},  32'd0);
        check("rst_strobes", {30'd0, bus_if.dmem_read, bus_if.dmem_write}, 32'd0);
        check("rst_address", bus_if.dmem_address, 32'd0);
        check("rst_mbe_wdata", {28'd0, bus_if.dmem_mbe} | bus_if.dmem_wdata, 32'd0);
        check("rst_load_done", bus_if.load_data | {31'd0, bus_if.done}, 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

        // Stray response while idle must do nothing.
        bus_if.dmem_resp = 1'b1;
        @(negedge clk);
        bus_if.dmem_resp = 1'b0;
        @(negedge clk);
        check("idle_resp_done", {31'd0, bus_if.done}, 32'd0);

        do_access(1'b1, 3'd2, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0, 32'h0000_0100, 4'b1111, 32'd0, 32'hDEAD_BEEF);
        idle_cycle();
        do_access(1'b1, 3'd0, 32'h0000_0203, 32'd0, 32'h8011_2233, 0, 32'h0000_0200, 4'b1000, 32'd0, 32'hFFFF_FF80);
        idle_cycle();
        do_access(1'b1, 3'd4, 32'h0000_0203, 32'd0, 32'h8011_2233, 0, 32'h0000_0200, 4'b1000, 32'd0, 32'h0000_0080);
        idle_cycle();
        do_access(1'b1, 3'd5, 32'h0000_0202, 32'd0, 32'h8011_2233, 0, 32'h0000_0200, 4'b1100, 32'd0, 32'h0000_8011);
        idle_cycle();
        do_access(1'b1, 3'd1, 32'h0000_0202, 32'd0, 32'h8011_2233, 1, 32'h0000_0200, 4'b1100, 32'd0, 32'hFFFF_8011);
        idle_cycle();
        do_access(1'b0, 3'd1, 32'h0000_0306, 32'h0000_ABCD, 32'd0, 4, 32'h0000_0304, 4'b1100, 32'hABCD_0000, 32'd0);
        idle_cycle();
        do_access(1'b0, 3'd0, 32'h0000_0101, 32'h0000_00A5, 32'd0, 0, 32'h0000_0100, 4'b0010, 32'h0000_A500, 32'd0);
        idle_cycle();
        do_access(1'b1, 3'd0, 32'h0000_0011, 32'd0, 32'h1234_5678, 2, 32'h0000_0010, 4'b0010, 32'd0, 32'h0000_0056);

        // Misaligned and illegal accesses, back to back while idle.
        trap_case("lw_mis",   1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_0101, 1'b1);
        trap_case("sh_mis",   1'b1, 1'b0, 1'b1, 3'd1, 32'h0000_0003, 1'b1);
        trap_case("ld_f3_3",  1'b1, 1'b1, 1'b0, 3'd3, 32'h0000_0000, 1'b1);
        trap_case("ld_f3_6",  1'b1, 1'b1, 1'b0, 3'd6, 32'h0000_0000, 1'b1);
        trap_case("st_f3_4",  1'b1, 1'b0, 1'b1, 3'd4, 32'h0000_0000, 1'b1);
        trap_case("rd_and_wr",1'b1, 1'b1, 1'b1, 3'd2, 32'h0000_0000, 1'b1);
        trap_case("no_valid", 1'b0, 1'b1, 1'b0, 3'd2, 32'h0000_0101, 1'b0);
        trap_case("no_strobe",1'b1, 1'b0, 1'b0, 3'd7, 32'h0000_0001, 1'b0);

        // Back-to-back: store held through DONE, then a load straight from IDLE.
        do_access(1'b0, 3'd2, 32'h0000_0500, 32'hCAFE_F00D, 32'd0, 0, 32'h0000_0500, 4'b1111, 32'hCAFE_F00D, 32'd0);
        do_access(1'b1, 3'd2, 32'h0000_0504, 32'd0, 32'h0BAD_F00D, 2, 32'h0000_0504, 4'b1111, 32'd0, 32'h0BAD_F00D);
        idle_cycle();

        // Reset during the second BUSY cycle aborts; the late response is ignored.
        r.addr = 32'h0000_0400; r.mbe = 4'b1111; r.wdata = 32'd0; r.wr = 1'b0; r.hold = 2;
        req_q.push_back(r);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_0400, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_rst_stall", {31'd0, bus_if.stall}, 32'd0);
        check("abort_rst_trap",  {31'd0, bus_if.trap},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        bus_if.dmem_resp  = 1'b1;
        bus_if.dmem_rdata = 32'h5555_AAAA;
        check("abort_strobes", {30'd0, bus_if.dmem_read, bus_if.dmem_write}, 32'd0);
        check("abort_address", bus_if.dmem_address, 32'd0);
        @(negedge clk);
        bus_if.dmem_resp = 1'b0;
        check("abort_no_done", {31'd0, bus_if.done}, 32'd0);
        @(negedge clk);
        check("abort_load_data", bus_if.load_data, 32'd0);

        do_access(1'b1, 3'd2, 32'h0000_0600, 32'd0, 32'h0F0F_1234, 0, 32'h0000_0600, 4'b1111, 32'd0, 32'h0F0F_1234);
        idle_cycle();
        repeat (3) @(negedge clk);

        check("req_q_empty",  req_q.size(), 32'd0);
        check("done_q_empty", done_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation watchdog expired");
    end
endmodule
